pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: match sequencer for a two-player pong game.
// Walks IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER), keeps both scores,
// and issues the per-frame physics strobe and ball-centre pulse.
// Optional feature: define PONG_CTRL_PAUSE_EN to enable the PAUSE state
// driven by pause_btn_i rising edges while in PLAY.
module pong_game_ctrl #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       frame_tick_i,
    input  logic       start_btn_i,
    input  logic       pause_btn_i,
    input  logic       miss_l_i,
    input  logic       miss_r_i,
    output logic       update_o,
    output logic       ball_reset_o,
    output logic       serve_dir_o,
    output logic [3:0] score_l_o,
    output logic [3:0] score_r_o,
    output logic [2:0] state_o,
    output logic       game_over_o,
    output logic       winner_o
);

    localparam int unsigned MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4,
        PAUSE = 3'd5
    } state_t;

    state_t           state;
    logic             start_q;
    logic             pause_q;
    logic [CNT_W-1:0] frame_cnt;

    logic start_rise;
    logic pause_rise;
    logic serve_done;
    logic point_done;

    // Button edge detection; edge registers reset high so a held button is not an edge.
    assign start_rise = start_btn_i & ~start_q;
    assign pause_rise = pause_btn_i & ~pause_q;

    // The N-th frame tick of a timed state ends it at this edge.
    assign serve_done = frame_tick_i && (frame_cnt == SERVE_LAST);
    assign point_done = frame_tick_i && (frame_cnt == POINT_LAST);

`ifndef PONG_CTRL_PAUSE_EN
    // Pause is not built in; the edge is computed but deliberately left unused.
    logic pause_rise_unused;
    assign pause_rise_unused = pause_rise;
`endif

    assign state_o = state;

    // Game state machine with registered scores, strobes and status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            start_q      <= 1'b1;
            pause_q      <= 1'b1;
            frame_cnt    <= '0;
            score_l_o    <= 4'd0;
            score_r_o    <= 4'd0;
            serve_dir_o  <= 1'b1;
            update_o     <= 1'b0;
            ball_reset_o <= 1'b0;
            game_over_o  <= 1'b0;
            winner_o     <= 1'b0;
        end else begin
            start_q      <= start_btn_i;
            pause_q      <= pause_btn_i;
            ball_reset_o <= 1'b0;
            update_o     <= frame_tick_i && (state == PLAY);
            if (frame_tick_i) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end

            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state        <= SERVE;
                        score_l_o    <= 4'd0;
                        score_r_o    <= 4'd0;
                        serve_dir_o  <= 1'b1;
                        game_over_o  <= 1'b0;
                        winner_o     <= 1'b0;
                        ball_reset_o <= 1'b1;
                        frame_cnt    <= '0;
                    end
                end

                SERVE: begin
                    if (serve_done) begin
                        state <= PLAY;
                    end
                end

                PLAY: begin
                    if (miss_l_i && miss_r_i) begin
                        state     <= POINT;
                        frame_cnt <= '0;
                    end else if (miss_l_i) begin
                        if (score_r_o != WIN) begin
                            score_r_o <= score_r_o + 4'd1;
                        end
                        serve_dir_o <= 1'b0;
                        state       <= POINT;
                        frame_cnt   <= '0;
                    end else if (miss_r_i) begin
                        if (score_l_o != WIN) begin
                            score_l_o <= score_l_o + 4'd1;
                        end
                        serve_dir_o <= 1'b1;
                        state       <= POINT;
                        frame_cnt   <= '0;
                    end
`ifdef PONG_CTRL_PAUSE_EN
                    else if (pause_rise) begin
                        state <= PAUSE;
                    end
`endif
                end

                POINT: begin
                    if (point_done) begin
                        frame_cnt <= '0;
                        if ((score_l_o == WIN) || (score_r_o == WIN)) begin
                            state       <= OVER;
                            game_over_o <= 1'b1;
                            winner_o    <= (score_r_o == WIN);
                        end else begin
                            state        <= SERVE;
                            ball_reset_o <= 1'b1;
                        end
                    end
                end

`ifdef PONG_CTRL_PAUSE_EN
                PAUSE: begin
                    if (pause_rise) begin
                        state <= PLAY;
                    end
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
